// File: rtl/sram_ctrl.sv
// SRAM access sequencer: precharge, wordline and sense phases with real-valued
// analog-facing strobes and a logic-level request/response interface.
module sram_ctrl #(
    parameter int ROWS    = 16,
    parameter int COLS    = 8,
    parameter int T_PRE   = 2,
    parameter int T_WL    = 2,
    parameter int T_SENSE = 1,
    localparam int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [COLS-1:0] wdata,
    output logic            ready,
    output logic            rvalid,
    output logic [COLS-1:0] rdata,
    output logic            err,
    output real             row_sel [0:AW-1],
    output real             pre_en,
    output real             wl_en,
    output real             sae,
    output real             wr_en,
    output real             bl_drv [0:COLS-1],
    input  real             sense_in [0:COLS-1]
);

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    localparam int TMAX_PW = (T_PRE > T_WL) ? T_PRE : T_WL;
    localparam int TMAX    = (TMAX_PW > T_SENSE) ? TMAX_PW : T_SENSE;
    localparam int CW      = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] PRE_LOAD   = CW'(T_PRE - 1);
    localparam logic [CW-1:0] WL_LOAD    = CW'(T_WL - 1);
    localparam logic [CW-1:0] SENSE_LOAD = CW'(T_SENSE - 1);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW:0]   ROWS_LIM   = (AW + 1)'(ROWS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_WL    = 3'd2,
        S_SENSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;

    logic [AW-1:0]   addr_r, addr_s;
    logic            we_r, we_s;
    logic [COLS-1:0] wdata_r, wdata_s;
    logic            bad_r, bad_s;
    logic            accept_s;

    logic            ready_r, ready_s;
    logic            rvalid_r, rvalid_s;
    logic            err_r, err_s;
    logic            pre_r, pre_s;
    logic            wl_r, wl_s;
    logic            sae_r, sae_s;
    logic            wr_r, wr_s;
    logic [AW-1:0]   row_r, row_s;
    logic [COLS-1:0] bl_r, bl_s;
    logic [COLS-1:0] rdata_r;
    logic [COLS-1:0] sense_bits_s;

    // Acceptance is qualified by the registered ready, so busy-time requests vanish.
    always_comb begin
        accept_s = req & ready_r;
        if (accept_s) begin
            addr_s  = addr;
            we_s    = we;
            wdata_s = wdata;
            bad_s   = !({1'b0, addr} < ROWS_LIM);
        end else begin
            addr_s  = addr_r;
            we_s    = we_r;
            wdata_s = wdata_r;
            bad_s   = bad_r;
        end
    end

    // State register, phase counter and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
            addr_r  <= {AW{1'b0}};
            we_r    <= 1'b0;
            wdata_r <= {COLS{1'b0}};
            bad_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            we_r    <= we_s;
            wdata_r <= wdata_s;
            bad_r   <= bad_s;
        end
    end

    // Next-state and phase-counter logic; each phase entry reloads the counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && bad_s) begin
                    state_s = S_DONE;
                end else if (accept_s) begin
                    state_s = S_PRE;
                    cnt_s   = PRE_LOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PRE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = S_WL;
                    cnt_s   = WL_LOAD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            S_WL: begin
                if (cnt_r == CNT_ZERO && we_r) begin
                    state_s = S_DONE;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = S_SENSE;
                    cnt_s   = SENSE_LOAD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            S_SENSE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = S_DONE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the upcoming state so every strobe comes straight from a flop.
    always_comb begin
        ready_s  = (state_s == S_IDLE);
        pre_s    = (state_s == S_PRE);
        wl_s     = (state_s == S_WL);
        sae_s    = (state_s == S_SENSE);
        wr_s     = (state_s == S_WL) && we_s;
        rvalid_s = (state_s == S_DONE) && !we_s && !bad_s;
        err_s    = (state_s == S_DONE) && bad_s;
        if (state_s == S_IDLE) begin
            row_s = {AW{1'b0}};
        end else begin
            row_s = addr_s;
        end
        if (wr_s) begin
            bl_s = wdata_s;
        end else begin
            bl_s = {COLS{1'b0}};
        end
    end

    // Registered outputs; reset clears them at once, aborting any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r  <= 1'b0;
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            pre_r    <= 1'b0;
            wl_r     <= 1'b0;
            sae_r    <= 1'b0;
            wr_r     <= 1'b0;
            row_r    <= {AW{1'b0}};
            bl_r     <= {COLS{1'b0}};
        end else begin
            ready_r  <= ready_s;
            rvalid_r <= rvalid_s;
            err_r    <= err_s;
            pre_r    <= pre_s;
            wl_r     <= wl_s;
            sae_r    <= sae_s;
            wr_r     <= wr_s;
            row_r    <= row_s;
            bl_r     <= bl_s;
        end
    end

    // Read data is sampled on the last sense edge and held until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {COLS{1'b0}};
        end else if (state_r == S_SENSE && cnt_r == CNT_ZERO) begin
            rdata_r <= sense_bits_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign ready  = ready_r;
    assign rvalid = rvalid_r;
    assign err    = err_r;
    assign rdata  = rdata_r;

    assign pre_en = pre_r ? VDD : VSS;
    assign wl_en  = wl_r  ? VDD : VSS;
    assign sae    = sae_r ? VDD : VSS;
    assign wr_en  = wr_r  ? VDD : VSS;

    for (genvar i = 0; i < AW; i++) begin : g_row
        assign row_sel[i] = row_r[i] ? VDD : VSS;
    end

    // Sense-amp outputs are sliced at VTH; bitline drive is full-rail only.
    for (genvar i = 0; i < COLS; i++) begin : g_col
        assign bl_drv[i]       = bl_r[i] ? VDD : VSS;
        assign sense_bits_s[i] = (sense_in[i] >= VTH);
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: the bench plays the SRAM array and predicts
// every strobe cycle-by-cycle from the phase lengths.
module tb_sram_ctrl;

    localparam int ROWS    = 12;
    localparam int COLS    = 8;
    localparam int T_PRE   = 2;
    localparam int T_WL    = 2;
    localparam int T_SENSE = 1;
    localparam int AW      = $clog2(ROWS);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req;
    logic            we;
    logic [AW-1:0]   addr;
    logic [COLS-1:0] wdata;
    logic            ready;
    logic            rvalid;
    logic [COLS-1:0] rdata;
    logic            err;
    real             row_sel [0:AW-1];
    real             pre_en;
    real             wl_en;
    real             sae;
    real             wr_en;
    real             bl_drv [0:COLS-1];
    real             sense_in [0:COLS-1];

    int              total = 0;
    int              bad   = 0;
    logic [COLS-1:0] mem [0:ROWS-1];
    logic [COLS-1:0] rdata_exp;
    real             hi_tab [0:2] = '{1.5, 0.8, 1.2};
    real             lo_tab [0:2] = '{0.0, 0.79, 0.3};

    sram_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .T_PRE(T_PRE), .T_WL(T_WL), .T_SENSE(T_SENSE)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err),
        .row_sel(row_sel), .pre_en(pre_en), .wl_en(wl_en), .sae(sae), .wr_en(wr_en),
        .bl_drv(bl_drv), .sense_in(sense_in)
    );

    always #5 clk = ~clk;

    function automatic logic lvl(input real v);
        if (v == 1.5) return 1'b1;
        else if (v == 0.0) return 1'b0;
        else return 1'bx;
    endfunction

    function automatic logic [AW-1:0] row_bits();
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = lvl(row_sel[i]);
        return r;
    endfunction

    function automatic logic [COLS-1:0] bl_bits();
        logic [COLS-1:0] r;
        for (int i = 0; i < COLS; i++) r[i] = lvl(bl_drv[i]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input logic e_pre, input logic e_wl, input logic e_sae,
                            input logic e_wr, input logic [AW-1:0] e_row,
                            input logic [COLS-1:0] e_bl, input logic e_rv,
                            input logic e_err, input logic e_rdy);
        chk("pre_en", lvl(pre_en), e_pre);
        chk("wl_en", lvl(wl_en), e_wl);
        chk("sae", lvl(sae), e_sae);
        chk("wr_en", lvl(wr_en), e_wr);
        chk("row_sel", row_bits(), e_row);
        chk("bl_drv", bl_bits(), e_bl);
        chk("rvalid", rvalid, e_rv);
        chk("err", err, e_err);
        chk("ready", ready, e_rdy);
        chk("rdata", rdata, rdata_exp);
    endtask

    // One access from the accepting edge through the idle cycle after DONE.
    task automatic run_access(input logic w, input logic [AW-1:0] a,
                              input logic [COLS-1:0] d, input real hi,
                              input real lo, input bit hold);
        bit              in_rng;
        int              wl_end, sense_end, len;
        logic [COLS-1:0] pat;
        logic            e_pre, e_wl, e_sae, e_wr, done;
        in_rng = (int'(a) < ROWS);
        pat = in_rng ? mem[a] : COLS'($urandom);
        for (int i = 0; i < COLS; i++) sense_in[i] = pat[i] ? hi : lo;
        chk("ready_pre_accept", ready, 1'b1);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        wl_end    = T_PRE + T_WL;
        sense_end = wl_end + (w ? 0 : T_SENSE);
        len       = in_rng ? sense_end + 1 : 1;
        for (int k = 1; k <= len; k++) begin
            req = hold; we = 1'($urandom); addr = AW'($urandom); wdata = COLS'($urandom);
            done  = (k == len);
            e_pre = in_rng && (k <= T_PRE);
            e_wl  = in_rng && (k > T_PRE) && (k <= wl_end);
            e_sae = in_rng && !w && (k > wl_end) && (k <= sense_end);
            e_wr  = e_wl && w;
            if (done && in_rng && !w) rdata_exp = pat;
            chk_outs(e_pre, e_wl, e_sae, e_wr, a, e_wr ? d : {COLS{1'b0}},
                     done && in_rng && !w, done && !in_rng, 1'b0);
            if (k < len) begin
                @(posedge clk); #1;
            end
        end
        if (in_rng && w) mem[a] = d;
        @(posedge clk); #1;
        chk_outs(1'b0, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, {COLS{1'b0}}, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = {AW{1'b0}}; wdata = {COLS{1'b0}};
        rdata_exp = {COLS{1'b0}};
        for (int i = 0; i < COLS; i++) sense_in[i] = 0.0;
        for (int i = 0; i < ROWS; i++) mem[i] = COLS'($urandom);

        // Reset state, then ready rises on the first edge after release.
        #3;
        chk_outs(1'b0, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, {COLS{1'b0}}, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("ready_in_reset_exit", ready, 1'b0);
        @(posedge clk); #1;
        chk("ready_after_reset", ready, 1'b1);

        // Canonical read 0xA5 from row 5, write 0x3C to row 3, read it back.
        mem[5] = 8'hA5;
        run_access(1'b0, 4'd5, 8'h00, 1.5, 0.0, 1'b0);
        run_access(1'b1, 4'd3, 8'h3C, 1.5, 0.0, 1'b0);
        run_access(1'b0, 4'd3, 8'h00, 1.5, 0.0, 1'b0);

        // Threshold: 0.80 reads as 1, 0.79 as 0.
        mem[7] = 8'h5A;
        run_access(1'b0, 4'd7, 8'h00, 0.80, 0.79, 1'b0);

        // Address boundary: last valid row and first/other invalid rows.
        run_access(1'b1, 4'd11, 8'hFF, 1.5, 0.0, 1'b0);
        run_access(1'b0, 4'd11, 8'h00, 1.5, 0.0, 1'b0);
        run_access(1'b0, 4'd13, 8'h00, 1.5, 0.0, 1'b0);
        run_access(1'b1, 4'd12, 8'h99, 1.5, 0.0, 1'b0);

        // req held high: busy-time requests with junk fields must be ignored.
        for (int n = 0; n < 6; n++)
            run_access(1'($urandom), AW'($urandom_range(0, 11)), COLS'($urandom),
                       1.5, 0.0, 1'b1);
        req = 1'b0;

        // Reset during the wordline phase of a read aborts it asynchronously.
        mem[2] = 8'hC3;
        for (int i = 0; i < COLS; i++) sense_in[i] = mem[2][i] ? 1.5 : 0.0;
        req = 1'b1; we = 1'b0; addr = 4'd2;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (T_PRE) @(posedge clk);
        #1;
        chk("wl_before_abort", lvl(wl_en), 1'b1);
        #2; rst_n = 1'b0; #1;
        rdata_exp = {COLS{1'b0}};
        chk_outs(1'b0, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, {COLS{1'b0}}, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_outs(1'b0, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, {COLS{1'b0}}, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk_outs(1'b0, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, {COLS{1'b0}}, 1'b0, 1'b0, 1'b1);
        run_access(1'b0, 4'd2, 8'h00, 1.5, 0.0, 1'b0);

        // Randomized mix of reads, writes, bad addresses and analog levels.
        for (int n = 0; n < 40; n++)
            run_access(1'($urandom), AW'($urandom_range(0, 15)), COLS'($urandom),
                       hi_tab[$urandom_range(0, 2)], lo_tab[$urandom_range(0, 2)],
                       1'($urandom));
        req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter ROWS, default 16, SHALL set the number of SRAM rows; address width AW = $clog2(ROWS).
REQ-002 Parameter COLS, default 8, SHALL set the data word width (bitlines per row).
REQ-003 Parameter T_PRE, default 2, SHALL set the precharge phase length in cycles (>=1).
REQ-004 Parameter T_WL, default 2, SHALL set the wordline phase length in cycles (>=1).
REQ-005 Parameter T_SENSE, default 1, SHALL set the sense phase length in cycles (>=1).
REQ-006 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-007 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 req  input  1  SHALL be the access request, qualified by ready.
REQ-009 we  input  1  SHALL select write (1) or read (0).
REQ-010 addr  input  AW  SHALL be the row address.
REQ-011 wdata  input  COLS  SHALL be the write data.
REQ-012 ready  output  1  SHALL be high only in IDLE while rst_n is high.
REQ-013 rvalid  output  1  SHALL be a one-cycle read-data-valid pulse.
REQ-014 rdata  output  COLS  SHALL be the captured read data.
REQ-015 err  output  1  SHALL be a one-cycle pulse flagging an out-of-range address.
REQ-016 row_sel  output  real [0:AW-1]  SHALL carry the binary row address to the decoder, LSB at index 0.
REQ-017 pre_en, wl_en, sae, wr_en  output  real  SHALL be the precharge, wordline-enable, sense-amp-enable and write-enable strobes.
REQ-018 bl_drv  output  real [0:COLS-1]  SHALL be the write bitline drive.
REQ-019 sense_in  input  real [0:COLS-1]  SHALL be the sense-amp outputs.

Function
REQ-020 Real outputs SHALL be driven only at VDD = 1.5 (logic 1) or VSS = 0.0 (logic 0); a real input bit SHALL be 1 iff it is >= VTH = 0.8.
REQ-021 The FSM SHALL have the states IDLE, PRE, WL, SENSE and DONE.
REQ-022 A request SHALL be accepted on an edge where req=1 and ready=1; addr, we and wdata SHALL be latched on that edge, and req while not ready SHALL be ignored (no queuing).
REQ-023 On acceptance with addr < ROWS: IDLE->PRE; PRE SHALL last T_PRE cycles with pre_en=VDD and all other strobes VSS.
REQ-024 On acceptance with addr >= ROWS: IDLE->DONE with err=1 in DONE, no strobe asserted, and rvalid=0.
REQ-025 PRE->WL; WL SHALL last T_WL cycles with wl_en=VDD, and for writes wr_en=VDD and bl_drv[i] = wdata[i] level.
REQ-026 After WL, a write SHALL go to DONE and a read SHALL go to SENSE.
REQ-027 SENSE SHALL last T_SENSE cycles with sae=VDD and wl_en=VSS; rdata SHALL be captured from sense_in on the final SENSE edge.
REQ-028 DONE SHALL last one cycle, with rvalid=1 for a valid read, and SHALL then return to IDLE unconditionally.
REQ-029 Read rvalid SHALL rise T_PRE+T_WL+T_SENSE edges after the accepting edge (5 with defaults); a write SHALL reach DONE T_PRE+T_WL edges after acceptance.
REQ-030 row_sel SHALL hold the latched address from acceptance through DONE and SHALL be all VSS in IDLE.
REQ-031 pre_en and wl_en SHALL never both be VDD; sae and wr_en SHALL never both be VDD.
REQ-032 bl_drv SHALL be VSS outside write WL cycles.
REQ-033 rdata SHALL hold its value until the next read capture.
REQ-034 Each phase counter SHALL be sized for max(T_PRE, T_WL, T_SENSE) and reload on every phase entry.

Reset
REQ-035 While rst_n=0, regardless of clk: state=IDLE; ready=0, rvalid=0, err=0, rdata=0; all real outputs VSS.
REQ-036 Reset asserted mid-access SHALL abort the access immediately, with no rvalid or err pulse; ready SHALL rise in the cycle following rst_n deassertion.

Verification
REQ-037 Read addr=5, sense_in pattern 0xA5 (1.5/0.0 levels) -> row_sel=1.5,0,1.5,0 (LSB first); pre_en 2 cycles, wl_en 2, sae 1; rvalid at edge 5; rdata=0xA5.
REQ-038 Write addr=3, wdata=0x3C -> wr_en and wl_en high 2 cycles; bl_drv=0x3C levels; no sae; no rvalid; ready high again after DONE.
REQ-039 req held high continuously -> back-to-back accesses accepted only in IDLE; req during PRE/WL/SENSE ignored.
REQ-040 ROWS=12, addr=13 -> err pulse one cycle after acceptance; all strobes stay VSS throughout.
REQ-041 rst_n pulsed low during WL of a read -> all strobes VSS asynchronously; no rvalid; next read completes normally.
REQ-042 sense_in at 0.79 / 0.80 -> captured bit 0 / 1.
